mem_access_seq: RTL and testbench

- Parametrised successor to the single-latency load-wait controller of the multicycle datapath.
- Sequences data-memory accesses for loads and stores with independent configurable latencies and an optional ack handshake with timeout.
- Gates the PC enable, register-file write enable, `mreq` and `write`.
- Sits between the decoder/datapath and the data memory port; the datapath ANDs `reg_write_en` with the decoder `reg_write`.

---
 rtl/mem_seq_pkg.sv | 31 +++
 rtl/sat_counter.sv | 25 ++
 rtl/mem_access_seq.sv | 179 +++++++++++++++++
 tb/tb_mem_access_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the data-memory access sequencer: opcodes,
// FSM state encoding and a constant-evaluable clog2 helper.
package mem_seq_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Ceiling log2; values 0 and 1 both give 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        res = res + 1;
        v = v >> 1;
      end
    end else begin
      res = 0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised saturating incrementer with synchronous clear.
// Clear has priority over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mem_access_seq.sv
// Data-memory access sequencer. Issues loads/stores, waits a configurable
// latency (optionally for an ack with timeout) and gates the PC enable and
// register-file write enable. Strobes are combinational from state/inputs
// so a completion is visible in the same cycle it is decided.
module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned STORE_LAT = 1,
  parameter int unsigned USE_ACK   = 0,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        opcode,
  input  logic              hold,
  input  logic              mem_ack,
  output logic              pc_enable,
  output logic              reg_write_en,
  output logic              mreq,
  output logic              write,
  output logic              busy,
  output logic              timeout_err,
  output logic [STAT_W-1:0] stall_cnt
);

  // With an ack handshake a store always needs a wait state to observe it.
  localparam int unsigned ST_LAT_EFF = ((USE_ACK != 0) && (STORE_LAT == 0)) ? 1 : STORE_LAT;
  localparam bit          ST_SINGLE  = (ST_LAT_EFF == 0);
  // Counter wide enough for the timeout and for any latency it must reach.
  localparam int unsigned MAX_A      = (LOAD_LAT > ST_LAT_EFF) ? LOAD_LAT : ST_LAT_EFF;
  localparam int unsigned MAX_CNT    = (TIMEOUT > MAX_A) ? TIMEOUT : MAX_A;
  localparam int unsigned CNT_W      = clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] LD_LAT_C = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] ST_LAT_C = CNT_W'(ST_LAT_EFF);
  localparam logic [CNT_W-1:0] TO_C     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             is_load;
  logic             is_store;
  logic             done;
  logic             timeout_hit;
  logic [CNT_W-1:0] wait_lat;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign busy     = (state != IDLE);

  // Wait-state completion and timeout detection.
  always_comb begin
    wait_lat    = (state == ST_WAIT) ? ST_LAT_C : LD_LAT_C;
    done        = 1'b0;
    timeout_hit = 1'b0;
    if (state != IDLE) begin
      done        = (cnt >= wait_lat) && ((USE_ACK == 0) || mem_ack);
      timeout_hit = !done && (USE_ACK != 0) && (cnt == TO_C) && !mem_ack;
    end else begin
      done        = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      timeout_err <= timeout_err | timeout_hit;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (hold) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else if (is_load) begin
          next_state = LD_WAIT;
          next_cnt   = ONE_C;
        end else if (is_store && !ST_SINGLE) begin
          next_state = ST_WAIT;
          next_cnt   = ONE_C;
        end else begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      end
      LD_WAIT, ST_WAIT: begin
        if (done || timeout_hit) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_state = state;
          next_cnt   = cnt + ONE_C;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Strobe generation; everything is forced low during reset.
  always_comb begin
    pc_enable    = 1'b0;
    reg_write_en = 1'b0;
    mreq         = 1'b0;
    write        = 1'b0;
    if (rst) begin
      pc_enable    = 1'b0;
      reg_write_en = 1'b0;
      mreq         = 1'b0;
      write        = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hold) begin
            mreq = 1'b0;
          end else if (is_load) begin
            mreq = 1'b1;
          end else if (is_store) begin
            mreq  = 1'b1;
            write = 1'b1;
            if (ST_SINGLE) begin
              pc_enable    = 1'b1;
              reg_write_en = 1'b1;
            end else begin
              pc_enable    = 1'b0;
              reg_write_en = 1'b0;
            end
          end else begin
            pc_enable    = 1'b1;
            reg_write_en = 1'b1;
          end
        end
        LD_WAIT, ST_WAIT: begin
          mreq  = 1'b1;
          write = (state == ST_WAIT);
          if (done) begin
            pc_enable    = 1'b1;
            reg_write_en = 1'b1;
          end else if (timeout_hit) begin
            pc_enable    = 1'b1;
            reg_write_en = 1'b0;
          end else begin
            pc_enable    = 1'b0;
            reg_write_en = 1'b0;
          end
        end
        default: begin
          mreq = 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(STAT_W)) u_stall (
    .clk   (clk),
    .clear (rst),
    .inc   (!pc_enable),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: three instances with different
// parameter sets, each driven in turn by a linear sequence of steps.
module tb_mem_access_seq;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OTHER = 7'b0110011;

  logic clk;
  int   n_vec;
  int   n_err;

  // Instance A: LOAD_LAT=2, STORE_LAT=0, no ack.
  logic rst_a, hold_a, ack_a, pc_a, rwe_a, mreq_a, wr_a, busy_a, to_a;
  logic [6:0]  op_a;
  logic [31:0] stall_a;
  // Instance B: LOAD_LAT=1, STORE_LAT=0, ack with TIMEOUT=5.
  logic rst_b, hold_b, ack_b, pc_b, rwe_b, mreq_b, wr_b, busy_b, to_b;
  logic [6:0]  op_b;
  logic [31:0] stall_b;
  // Instance C: LOAD_LAT=3, 3-bit stall counter.
  logic rst_c, hold_c, ack_c, pc_c, rwe_c, mreq_c, wr_c, busy_c, to_c;
  logic [6:0] op_c;
  logic [2:0] stall_c;

  mem_access_seq #(.LOAD_LAT(2), .STORE_LAT(0), .USE_ACK(0), .TIMEOUT(15), .STAT_W(32)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(op_a), .hold(hold_a), .mem_ack(ack_a),
    .pc_enable(pc_a), .reg_write_en(rwe_a), .mreq(mreq_a), .write(wr_a),
    .busy(busy_a), .timeout_err(to_a), .stall_cnt(stall_a));

  mem_access_seq #(.LOAD_LAT(1), .STORE_LAT(0), .USE_ACK(1), .TIMEOUT(5), .STAT_W(32)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(op_b), .hold(hold_b), .mem_ack(ack_b),
    .pc_enable(pc_b), .reg_write_en(rwe_b), .mreq(mreq_b), .write(wr_b),
    .busy(busy_b), .timeout_err(to_b), .stall_cnt(stall_b));

  mem_access_seq #(.LOAD_LAT(3), .STORE_LAT(1), .USE_ACK(0), .TIMEOUT(15), .STAT_W(3)) dut_c (
    .clk(clk), .rst(rst_c), .opcode(op_c), .hold(hold_c), .mem_ack(ack_c),
    .pc_enable(pc_c), .reg_write_en(rwe_c), .mreq(mreq_c), .write(wr_c),
    .busy(busy_c), .timeout_err(to_c), .stall_cnt(stall_c));

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    op_a = OTHER; op_b = OTHER; op_c = OTHER;
    hold_a = 1'b0; hold_b = 1'b0; hold_c = 1'b0;
    ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;

    // Reset cycle: strobes low even with an OTHER opcode.
    sample();
    chk("rst_pc", pc_a, 0);
    chk("rst_rwe", rwe_a, 0);
    chk("rst_mreq", mreq_a, 0);
    next_cycle();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    sample();
    chk("rst_busy", busy_a, 0);
    chk("rst_stall", stall_a, 0);
    chk("rst_to", to_b, 0);

    // A: OTHER for 4 cycles.
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("oth_pc", pc_a, 1);
      chk("oth_rwe", rwe_a, 1);
      chk("oth_mreq", mreq_a, 0);
      chk("oth_stall", stall_a, 0);
      next_cycle();
    end

    // A: load with LOAD_LAT=2.
    op_a = LOAD;
    sample();
    chk("ld0_mreq", mreq_a, 1);
    chk("ld0_pc", pc_a, 0);
    chk("ld0_rwe", rwe_a, 0);
    chk("ld0_busy", busy_a, 0);
    next_cycle();
    op_a = OTHER;
    sample();
    chk("ld1_mreq", mreq_a, 1);
    chk("ld1_pc", pc_a, 0);
    chk("ld1_busy", busy_a, 1);
    chk("ld1_wr", wr_a, 0);
    next_cycle();
    sample();
    chk("ld2_mreq", mreq_a, 1);
    chk("ld2_pc", pc_a, 1);
    chk("ld2_rwe", rwe_a, 1);
    chk("ld2_busy", busy_a, 1);
    next_cycle();
    sample();
    chk("ld3_busy", busy_a, 0);
    chk("ld3_stall", stall_a, 2);
    chk("ld3_mreq", mreq_a, 0);
    next_cycle();

    // A: single-cycle store.
    op_a = STORE;
    sample();
    chk("st_mreq", mreq_a, 1);
    chk("st_wr", wr_a, 1);
    chk("st_pc", pc_a, 1);
    chk("st_rwe", rwe_a, 1);
    chk("st_busy", busy_a, 0);
    next_cycle();
    op_a = OTHER;
    sample();
    chk("st1_busy", busy_a, 0);
    chk("st1_stall", stall_a, 2);
    next_cycle();

    // A: hold blocks a load issue.
    hold_a = 1'b1;
    op_a = LOAD;
    sample();
    chk("hold_mreq", mreq_a, 0);
    chk("hold_pc", pc_a, 0);
    chk("hold_rwe", rwe_a, 0);
    next_cycle();
    hold_a = 1'b0;
    op_a = OTHER;
    sample();
    chk("hold1_stall", stall_a, 3);
    chk("hold1_busy", busy_a, 0);
    chk("hold1_pc", pc_a, 1);
    next_cycle();

    // B: load, ack already high at issue (ignored), completes at counter 1.
    op_b = LOAD;
    ack_b = 1'b1;
    sample();
    chk("bl0_mreq", mreq_b, 1);
    chk("bl0_pc", pc_b, 0);
    next_cycle();
    op_b = OTHER;
    sample();
    chk("bl1_pc", pc_b, 1);
    chk("bl1_rwe", rwe_b, 1);
    chk("bl1_busy", busy_b, 1);
    next_cycle();
    ack_b = 1'b0;
    sample();
    chk("bl2_busy", busy_b, 0);
    next_cycle();

    // B: load with ack at counter 4.
    op_b = LOAD;
    sample();
    chk("bm0_pc", pc_b, 0);
    next_cycle();
    op_b = OTHER;
    for (int k = 1; k < 4; k++) begin
      sample();
      chk("bm_wait_pc", pc_b, 0);
      chk("bm_wait_mreq", mreq_b, 1);
      next_cycle();
    end
    ack_b = 1'b1;
    sample();
    chk("bm4_pc", pc_b, 1);
    chk("bm4_rwe", rwe_b, 1);
    chk("bm4_to", to_b, 0);
    next_cycle();
    ack_b = 1'b0;
    sample();
    chk("bm5_busy", busy_b, 0);
    next_cycle();

    // B: no ack, timeout at counter 5.
    op_b = LOAD;
    sample();
    next_cycle();
    op_b = OTHER;
    for (int k = 1; k < 5; k++) begin
      sample();
      chk("bt_wait_pc", pc_b, 0);
      next_cycle();
    end
    sample();
    chk("bt5_pc", pc_b, 1);
    chk("bt5_rwe", rwe_b, 0);
    chk("bt5_mreq", mreq_b, 1);
    chk("bt5_to", to_b, 0);
    next_cycle();
    sample();
    chk("bt6_to", to_b, 1);
    chk("bt6_busy", busy_b, 0);
    next_cycle();

    // B: STORE_LAT=0 with ack behaves as one wait cycle; flag stays sticky.
    op_b = STORE;
    sample();
    chk("bs0_mreq", mreq_b, 1);
    chk("bs0_wr", wr_b, 1);
    chk("bs0_pc", pc_b, 0);
    chk("bs0_busy", busy_b, 0);
    next_cycle();
    op_b = OTHER;
    ack_b = 1'b1;
    sample();
    chk("bs1_pc", pc_b, 1);
    chk("bs1_rwe", rwe_b, 1);
    chk("bs1_wr", wr_b, 1);
    next_cycle();
    ack_b = 1'b0;
    sample();
    chk("bs2_to", to_b, 1);
    chk("bs2_busy", busy_b, 0);
    next_cycle();
    rst_b = 1'b1;
    sample();
    next_cycle();
    rst_b = 1'b0;
    sample();
    chk("brst_to", to_b, 0);
    next_cycle();

    // C: reset during a LOAD_LAT=3 load.
    op_c = LOAD;
    sample();
    chk("cl0_mreq", mreq_c, 1);
    next_cycle();
    op_c = OTHER;
    rst_c = 1'b1;
    sample();
    chk("crst_mreq", mreq_c, 0);
    chk("crst_pc", pc_c, 0);
    chk("crst_rwe", rwe_c, 0);
    chk("crst_wr", wr_c, 0);
    next_cycle();
    rst_c = 1'b0;
    sample();
    chk("cpost_busy", busy_c, 0);
    chk("cpost_pc", pc_c, 1);
    chk("cpost_stall", stall_c, 0);
    next_cycle();

    // C: 10 held cycles saturate the 3-bit stall counter at 7.
    hold_c = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      sample();
      chk("csat_stall", stall_c, (k - 1 > 7) ? 7 : k - 1);
      next_cycle();
    end
    hold_c = 1'b0;
    sample();
    chk("csat_final", stall_c, 7);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
